switch_scheduler: RTL and testbench

- Time-multiplexed transfer scheduler for the inter-core switch shared by MatCore/VecCore instances.
- Detects send/recv rendezvous pairs, grants one pair at a time with round-robin fairness over receivers, and sequences a WIDTH-word transfer as BEATS bus beats.
- Drives the per-core send_ok/recv_ready completion pulses.
- Sits between the cores' switch request ports and the shared data lane.

---
 rtl/switch_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/switch_scheduler.sv | 142 ++++++++++++++
 tb/tb_switch_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared scheduler types and default switch geometry for the switch and the cores.
package switch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int CORE_SIZE_DEF = 8;
  localparam int WIDTH_DEF     = 64;
  localparam int BUS_WORDS_DEF = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr_i (wrapping).
// Purely combinational so it can be replicated per lane in a multi-lane switch.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [AW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [AW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  // Walk ptr, ptr+1, ... and stop at the first requester found.
  always_comb begin
    logic found;
    int   j;
    found       = 1'b0;
    j           = 0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr_i) + i) % N;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        gnt_o[j]    = 1'b1;
        gnt_idx_o   = AW'(j);
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_scheduler.sv
// Inter-core switch transfer scheduler: pairs send/recv rendezvous, grants one
// pair at a time round-robin over receivers, and sequences BEATS lane beats.
//
// state | meaning
// IDLE  | look for a matched pair, grant first receiver from rr pointer
// XFER  | data lane active, one beat per cycle, watch for dropped requests
// DONE  | one-cycle send_ok/recv_ready pulse, bump count, advance rr pointer
module switch_scheduler
  import switch_pkg::*;
#(
  parameter  int CORE_SIZE = CORE_SIZE_DEF,
  parameter  int WIDTH     = WIDTH_DEF,
  parameter  int BUS_WORDS = BUS_WORDS_DEF,
  localparam int ADDR_SIZE = (CORE_SIZE > 1) ? $clog2(CORE_SIZE) : 1,
  localparam int BEATS     = WIDTH / BUS_WORDS,
  localparam int BEAT_SIZE = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [CORE_SIZE-1:0]                send_ready,
  input  logic [CORE_SIZE-1:0][ADDR_SIZE-1:0] send_core_idx,
  input  logic [CORE_SIZE-1:0]                recv_request,
  input  logic [CORE_SIZE-1:0][ADDR_SIZE-1:0] recv_core_idx,
  output logic [CORE_SIZE-1:0]                send_ok,
  output logic [CORE_SIZE-1:0]                recv_ready,
  output logic                                xfer_valid,
  output logic [ADDR_SIZE-1:0]                xfer_src,
  output logic [ADDR_SIZE-1:0]                xfer_dst,
  output logic [BEAT_SIZE-1:0]                xfer_beat,
  output logic                                busy,
  output logic                                protocol_err,
  output logic [31:0]                         xfer_count
);

  sched_state_t         state_q, state_d;
  logic [ADDR_SIZE-1:0] rr_ptr_q, rr_ptr_d;
  logic [ADDR_SIZE-1:0] src_q, src_d;
  logic [ADDR_SIZE-1:0] dst_q, dst_d;
  logic [BEAT_SIZE-1:0] beat_q, beat_d;
  logic [31:0]          count_q, count_d;
  logic                 err_q, err_d;

  logic [CORE_SIZE-1:0] match;
  logic [CORE_SIZE-1:0] gnt_onehot;
  logic [ADDR_SIZE-1:0] gnt_idx;
  logic                 gnt_valid;

  // Receiver r is matched when its chosen sender is ready and points back at r.
  always_comb begin
    logic [ADDR_SIZE-1:0] s;
    s     = '0;
    match = '0;
    for (int r = 0; r < CORE_SIZE; r++) begin
      s = recv_core_idx[r];
      match[r] = recv_request[r] && (int'(s) < CORE_SIZE) && send_ready[s] &&
                 (send_core_idx[s] == ADDR_SIZE'(r));
    end
  end

  rr_arbiter #(
    .N  (CORE_SIZE),
    .AW (ADDR_SIZE)
  ) u_rr_arbiter (
    .req_i       (match),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt_onehot),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  // Next-state logic; a granted transfer always runs to completion.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    src_d    = src_q;
    dst_d    = dst_q;
    beat_d   = beat_q;
    count_d  = count_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          src_d   = recv_core_idx[gnt_idx];
          dst_d   = gnt_idx;
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!send_ready[src_q] || !recv_request[dst_q]) err_d = 1'b1;
        if (beat_q == BEAT_SIZE'(BEATS - 1)) state_d = DONE;
        else                                 beat_d  = beat_q + BEAT_SIZE'(1);
      end
      DONE: begin
        count_d  = count_q + 32'd1;
        rr_ptr_d = (dst_q == ADDR_SIZE'(CORE_SIZE - 1)) ? '0 : dst_q + ADDR_SIZE'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any transfer without completion pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      beat_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      beat_q   <= beat_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Completion pulses; src==dst sets the same bit in both vectors.
  always_comb begin
    send_ok    = '0;
    recv_ready = '0;
    if (state_q == DONE) begin
      send_ok[src_q]    = 1'b1;
      recv_ready[dst_q] = 1'b1;
    end
  end

  assign xfer_valid   = (state_q == XFER);
  assign busy         = (state_q != IDLE);
  assign xfer_src     = src_q;
  assign xfer_dst     = dst_q;
  assign xfer_beat    = beat_q;
  assign protocol_err = err_q;
  assign xfer_count   = count_q;

endmodule

// File: tb/tb_switch_scheduler.sv
// Directed bench for switch_scheduler with default geometry (8 cores, 4 beats).
module tb_switch_scheduler;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       send_ready;
  logic [7:0][2:0]  send_core_idx;
  logic [7:0]       recv_request;
  logic [7:0][2:0]  recv_core_idx;
  logic [7:0]       send_ok;
  logic [7:0]       recv_ready;
  logic             xfer_valid;
  logic [2:0]       xfer_src;
  logic [2:0]       xfer_dst;
  logic [1:0]       xfer_beat;
  logic             busy;
  logic             protocol_err;
  logic [31:0]      xfer_count;

  int checks = 0;
  int errors = 0;

  switch_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .send_ready    (send_ready),
    .send_core_idx (send_core_idx),
    .recv_request  (recv_request),
    .recv_core_idx (recv_core_idx),
    .send_ok       (send_ok),
    .recv_ready    (recv_ready),
    .xfer_valid    (xfer_valid),
    .xfer_src      (xfer_src),
    .xfer_dst      (xfer_dst),
    .xfer_beat     (xfer_beat),
    .busy          (busy),
    .protocol_err  (protocol_err),
    .xfer_count    (xfer_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_req();
    send_ready    = '0;
    recv_request  = '0;
    send_core_idx = '0;
    recv_core_idx = '0;
  endtask

  task automatic test_reset();
    clear_req();
    repeat (3) tick();
    checks++;
    if (xfer_valid !== 1'b0 || busy !== 1'b0 || send_ok !== 8'h00 || recv_ready !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b busy=%0b send_ok=%h recv_ready=%h expected 0/0/00/00",
               xfer_valid, busy, send_ok, recv_ready);
    end
    checks++;
    if (xfer_count !== 32'd0 || protocol_err !== 1'b0 || xfer_src !== 3'd0 || xfer_dst !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs: count=%0d err=%0b src=%0d dst=%0d expected 0/0/0/0",
               xfer_count, protocol_err, xfer_src, xfer_dst);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_pair();
    send_ready[2] = 1'b1; send_core_idx[2] = 3'd5;
    recv_request[5] = 1'b1; recv_core_idx[5] = 3'd2;
    for (int b = 0; b < 4; b++) begin
      tick();
      checks++;
      if (xfer_valid !== 1'b1 || xfer_beat !== 2'(b) || xfer_src !== 3'd2 || xfer_dst !== 3'd5 ||
          send_ok !== 8'h00) begin
        errors++;
        $display("FAIL single_beat%0d: valid=%0b beat=%0d src=%0d dst=%0d send_ok=%h expected 1/%0d/2/5/00",
                 b, xfer_valid, xfer_beat, xfer_src, xfer_dst, send_ok, b);
      end
    end
    tick();
    checks++;
    if (send_ok !== 8'h04 || recv_ready !== 8'h20 || xfer_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: send_ok=%h recv_ready=%h valid=%0b expected 04/20/0",
               send_ok, recv_ready, xfer_valid);
    end
    clear_req();
    tick();
    checks++;
    if (xfer_count !== 32'd1 || busy !== 1'b0 || send_ok !== 8'h00) begin
      errors++;
      $display("FAIL single_count: count=%0d busy=%0b send_ok=%h expected 1/0/00",
               xfer_count, busy, send_ok);
    end
  endtask

  task automatic test_mismatch();
    int bad;
    bad = 0;
    send_ready[1] = 1'b1; send_core_idx[1] = 3'd3;
    recv_request[3] = 1'b1; recv_core_idx[3] = 3'd0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (busy !== 1'b0 || xfer_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || xfer_count !== 32'd1) begin
      errors++;
      $display("FAIL mismatch_nogrant: busy_cycles=%0d count=%0d expected 0/1", bad, xfer_count);
    end
    clear_req();
    tick();
  endtask

  task automatic test_self_transfer();
    int bad;
    bad = 0;
    send_ready[4] = 1'b1; send_core_idx[4] = 3'd4;
    recv_request[4] = 1'b1; recv_core_idx[4] = 3'd4;
    for (int b = 0; b < 4; b++) begin
      tick();
      if (xfer_valid !== 1'b1 || xfer_beat !== 2'(b) || xfer_src !== 3'd4 || xfer_dst !== 3'd4) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL self_beats: bad_beats=%0d expected 0", bad);
    end
    tick();
    checks++;
    if (send_ok !== 8'h10 || recv_ready !== 8'h10) begin
      errors++;
      $display("FAIL self_done: send_ok=%h recv_ready=%h expected 10/10", send_ok, recv_ready);
    end
    clear_req();
    tick();
    checks++;
    if (xfer_count !== 32'd2) begin
      errors++;
      $display("FAIL self_count: count=%0d expected 2", xfer_count);
    end
  endtask

  // Pointer is 5 here (last dst was 4), so the order must be 6, 7, 4 repeating.
  task automatic test_fairness();
    int exp_dst [6] = '{6, 7, 4, 6, 7, 4};
    int exp_src [6] = '{1, 2, 0, 1, 2, 0};
    int n;
    send_ready[0] = 1'b1; send_core_idx[0] = 3'd4; recv_request[4] = 1'b1; recv_core_idx[4] = 3'd0;
    send_ready[1] = 1'b1; send_core_idx[1] = 3'd6; recv_request[6] = 1'b1; recv_core_idx[6] = 3'd1;
    send_ready[2] = 1'b1; send_core_idx[2] = 3'd7; recv_request[7] = 1'b1; recv_core_idx[7] = 3'd2;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      while (xfer_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (xfer_valid !== 1'b1) begin
        errors++;
        $display("FAIL fair_timeout%0d: valid=%0b after %0d cycles expected 1", g, xfer_valid, n);
      end else if (xfer_dst !== 3'(exp_dst[g]) || xfer_src !== 3'(exp_src[g])) begin
        errors++;
        $display("FAIL fair_order%0d: src=%0d dst=%0d expected %0d/%0d",
                 g, xfer_src, xfer_dst, exp_src[g], exp_dst[g]);
      end
      repeat (4) tick();
      checks++;
      if (recv_ready !== (8'h01 << exp_dst[g]) || send_ok !== (8'h01 << exp_src[g])) begin
        errors++;
        $display("FAIL fair_pulse%0d: send_ok=%h recv_ready=%h expected %h/%h",
                 g, send_ok, recv_ready, 8'h01 << exp_src[g], 8'h01 << exp_dst[g]);
      end
      tick();
    end
    clear_req();
    tick();
    checks++;
    if (xfer_count !== 32'd8 || protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL fair_count: count=%0d err=%0b expected 8/0", xfer_count, protocol_err);
    end
  endtask

  task automatic test_drop_mid_transfer();
    send_ready[2] = 1'b1; send_core_idx[2] = 3'd5;
    recv_request[5] = 1'b1; recv_core_idx[5] = 3'd2;
    tick();
    tick();
    recv_request[5] = 1'b0;
    checks++;
    if (xfer_beat !== 2'd1 || protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL drop_pre: beat=%0d err=%0b expected 1/0", xfer_beat, protocol_err);
    end
    tick();
    checks++;
    if (protocol_err !== 1'b1 || xfer_valid !== 1'b1 || xfer_beat !== 2'd2) begin
      errors++;
      $display("FAIL drop_err: err=%0b valid=%0b beat=%0d expected 1/1/2",
               protocol_err, xfer_valid, xfer_beat);
    end
    tick();
    tick();
    checks++;
    if (send_ok !== 8'h04 || recv_ready !== 8'h20) begin
      errors++;
      $display("FAIL drop_done: send_ok=%h recv_ready=%h expected 04/20", send_ok, recv_ready);
    end
    clear_req();
    repeat (6) tick();
    checks++;
    if (protocol_err !== 1'b1 || xfer_count !== 32'd9) begin
      errors++;
      $display("FAIL drop_sticky: err=%0b count=%0d expected 1/9", protocol_err, xfer_count);
    end
  endtask

  task automatic test_async_reset();
    send_ready[1] = 1'b1; send_core_idx[1] = 3'd6;
    recv_request[6] = 1'b1; recv_core_idx[6] = 3'd1;
    repeat (3) tick();
    checks++;
    if (xfer_valid !== 1'b1 || xfer_beat !== 2'd2 || xfer_dst !== 3'd6) begin
      errors++;
      $display("FAIL areset_pre: valid=%0b beat=%0d dst=%0d expected 1/2/6", xfer_valid, xfer_beat, xfer_dst);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (xfer_valid !== 1'b0 || busy !== 1'b0 || send_ok !== 8'h00 || recv_ready !== 8'h00) begin
      errors++;
      $display("FAIL areset_now: valid=%0b busy=%0b send_ok=%h recv_ready=%h expected 0/0/00/00",
               xfer_valid, busy, send_ok, recv_ready);
    end
    // Reset clears the transfer counter and the sticky error flag.
    checks++;
    if (xfer_count !== 32'd0 || protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL areset_regs: count=%0d err=%0b expected 0/0", xfer_count, protocol_err);
    end
    tick();
    checks++;
    if (send_ok !== 8'h00 || recv_ready !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_hold: send_ok=%h recv_ready=%h busy=%0b expected 00/00/0", send_ok, recv_ready, busy);
    end
    #2 reset = 1'b1;
    tick();
    checks++;
    if (xfer_valid !== 1'b1 || xfer_src !== 3'd1 || xfer_dst !== 3'd6 || xfer_beat !== 2'd0) begin
      errors++;
      $display("FAIL areset_regrant: valid=%0b src=%0d dst=%0d beat=%0d expected 1/1/6/0",
               xfer_valid, xfer_src, xfer_dst, xfer_beat);
    end
    repeat (4) tick();
    checks++;
    if (send_ok !== 8'h02 || recv_ready !== 8'h40) begin
      errors++;
      $display("FAIL areset_done: send_ok=%h recv_ready=%h expected 02/40", send_ok, recv_ready);
    end
    clear_req();
    tick();
    checks++;
    if (xfer_count !== 32'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_count: count=%0d busy=%0b expected 1/0", xfer_count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_mismatch();
    test_self_transfer();
    test_fairness();
    test_drop_mid_transfer();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
